// File: rtl/display_pkg.sv
// Shared display constants, pixel record, writer FSM states and SRAM packing helpers.
package display_pkg;

  localparam logic [9:0] H_ACTIVE = 10'd640;
  localparam logic [8:0] V_ACTIVE = 9'd480;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic [5:0] r;
    logic [5:0] g;
    logic [5:0] b;
  } pixel_t;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StStrobe
  } wr_state_e;

  function automatic logic [15:0] pack_rgb565(input logic [5:0] r, input logic [5:0] g,
                                              input logic [5:0] b);
    return {r[5:1], g, b[5:1]};
  endfunction

  function automatic logic [19:0] pixel_addr(input logic [9:0] x, input logic [8:0] y);
    return {1'b0, y, x};
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO with full/empty flags; push and pop in the same cycle are both honoured.
module pixel_fifo #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // Extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]      wptr_q, rptr_q;
  logic             do_push, do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign empty    = (wptr_q == rptr_q);
  assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop_data = mem[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/sram_pixel_writer.sv
// Buffers pixel writes and drains them into the shared SRAM during owned enable slots.
// Optional SRAM_PIXEL_WRITER_CLIP_EN drops off-screen pixels and counts them in dropped_cnt.
module sram_pixel_writer
  import display_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ADDR_W     = 20
) (
  input  logic              clk50,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [9:0]        wr_x,
  input  logic [8:0]        wr_y,
  input  logic [5:0]        wr_red,
  input  logic [5:0]        wr_green,
  input  logic [5:0]        wr_blue,
  output logic              busy,
  output wire  [ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [15:0]       SRAM_DQ,
  output wire               SRAM_CE_N,
  output wire               SRAM_OE_N,
  output wire               SRAM_WE_N,
  output wire               SRAM_UB_N,
  output wire               SRAM_LB_N
`ifdef SRAM_PIXEL_WRITER_CLIP_EN
  ,
  output logic [15:0]       dropped_cnt
`endif
);

  wr_state_e         state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       data_q;
  logic              we_n_q;
  pixel_t            fifo_in, fifo_out;
  logic              fifo_full, fifo_empty;
  logic              accept, push, pop, drive;

  assign fifo_in  = '{x: wr_x, y: wr_y, r: wr_red, g: wr_green, b: wr_blue};
  assign wr_ready = rst_n && !fifo_full;
  assign accept   = wr_valid && wr_ready;

`ifdef SRAM_PIXEL_WRITER_CLIP_EN
  logic off_screen;
  assign off_screen = (wr_x >= H_ACTIVE) || (wr_y >= V_ACTIVE);
  assign push       = accept && !off_screen;

  always_ff @(posedge clk50) begin
    if (!rst_n) begin
      dropped_cnt <= '0;
    end else if (accept && off_screen && (dropped_cnt != 16'hFFFF)) begin
      dropped_cnt <= dropped_cnt + 16'd1;
    end
  end
`else
  assign push = accept;
`endif

  assign pop = enable && !fifo_empty && ((state_q == StIdle) || (state_q == StStrobe));

  pixel_fifo #(
    .WIDTH ($bits(pixel_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk50),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (fifo_in),
    .pop       (pop),
    .pop_data  (fifo_out),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk50) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      data_q  <= '0;
      we_n_q  <= 1'b1;
    end else if (enable) begin
      unique case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            addr_q  <= ADDR_W'(pixel_addr(fifo_out.x, fifo_out.y));
            data_q  <= pack_rgb565(fifo_out.r, fifo_out.g, fifo_out.b);
            state_q <= StSetup;
          end
        end
        StSetup: begin
          we_n_q  <= 1'b0;
          state_q <= StStrobe;
        end
        StStrobe: begin
          we_n_q <= 1'b1;
          if (!fifo_empty) begin
            addr_q  <= ADDR_W'(pixel_addr(fifo_out.x, fifo_out.y));
            data_q  <= pack_rgb565(fifo_out.r, fifo_out.g, fifo_out.b);
            state_q <= StSetup;
          end else begin
            state_q <= StIdle;
          end
        end
        default: begin
          we_n_q  <= 1'b1;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy = (state_q != StIdle) || !fifo_empty;

  // Pins are released whenever the slot is not ours or there is nothing to write.
  assign drive     = enable && (state_q != StIdle);
  assign SRAM_ADDR = drive ? addr_q : 'z;
  assign SRAM_DQ   = drive ? data_q : 'z;
  assign SRAM_CE_N = drive ? 1'b0   : 1'bz;
  assign SRAM_OE_N = drive ? 1'b1   : 1'bz;
  assign SRAM_WE_N = drive ? we_n_q : 1'bz;
  assign SRAM_UB_N = drive ? 1'b0   : 1'bz;
  assign SRAM_LB_N = drive ? 1'b0   : 1'bz;

endmodule

// File: doc/sram_pixel_writer.md
Name: sram_pixel_writer

Overview:
- Write-side SRAM port for the display path. The framebuffer reads pixels out of SRAM; this block writes them in.
- It accepts pixel writes (x, y, 6-bit RGB) over a valid/ready handshake and buffers them in an internal FIFO.
- It drains the FIFO into the shared 1Mx16 SRAM, only during cycles where its time-slot enable is high.
- It sits beside the framebuffer on the shared SRAM bus. It replaces the ad-hoc write logic in the drawing block as that block's back end.

Parameters:
- FIFO_DEPTH, 16, pixel entries buffered; power of two, minimum 2.
- ADDR_W, 20, SRAM address width.

Ports:
- clk50  in  1  system clock, 50 MHz.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk50.
- enable  in  1  SRAM ownership slot; high on alternate cycles.
- wr_valid  in  1  pixel write request.
- wr_ready  out  1  block can accept a pixel.
- wr_x  in  10  pixel column.
- wr_y  in  9  pixel row.
- wr_red / wr_green / wr_blue  in  6 each  pixel colour.
- busy  out  1  FIFO non-empty or a write in flight.
- SRAM_ADDR  out  20  SRAM address; Z outside the slot.
- SRAM_DQ  inout  16  write data; always Z when not writing.
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  SRAM controls; Z outside the slot.

Behaviour:
- Clock and reset: one clock, clk50. Reset is synchronous and active-low (rst_n).
- Reset (rst_n=0 at a clk50 rising edge):
  - FIFO emptied and FSM set to IDLE.
  - wr_ready=0 while rst_n=0; wr_ready=1 on the first cycle after release.
  - busy=0.
  - All SRAM pins Z.
- Handshake:
  - A pixel transfers on a rising edge with wr_valid=1 and wr_ready=1.
  - wr_ready = !fifo_full.
  - A push and a pop in the same cycle are both performed. A push is not accepted when full, even if a pop occurs in that cycle (no look-ahead).
  - wr_x, wr_y and colour must be stable only while wr_valid=1.
- Address: SRAM_ADDR = {1'b0, wr_y, wr_x}, i.e. y*1024 + x.
- Data: RGB565, {red[5:1], green[5:0], blue[5:1]}. UB_N=LB_N=0 during writes.
- FSM advances only on cycles with enable=1. Cycles with enable=0 hold state.
  - IDLE: if FIFO non-empty, pop into the hold register and go to SETUP.
  - SETUP: drive ADDR and DQ, CE_N=0, OE_N=1, WE_N=1; next enable cycle go to STROBE.
  - STROBE: ADDR and DQ held, WE_N=0. Next enable cycle: if FIFO non-empty, pop and go to SETUP; else go to IDLE.
- Throughput: 1 pixel per 2 enable slots (4 clk50 cycles) under continuous feed.
- Latency: first SETUP is driven on the first enable cycle at least 1 cycle after the push.
- Pin gating: all SRAM outputs equal the driven values when enable=1 and state≠IDLE; otherwise Z. In IDLE with enable=1 the pins are also Z, so the bus can be shared.
- OE_N is never driven low; DQ is never read.
- Reset mid-write: WE_N and all other pins go Z on the cycle after the reset edge. A pending pixel is lost and no partial write is retried.
- busy = (state≠IDLE) | !fifo_empty.

Optional Feature:
- Macro: SRAM_PIXEL_WRITER_CLIP_EN.
- Defined:
  - Pixels with wr_x ≥ 640 or wr_y ≥ 480 are accepted (handshake completes) but never pushed.
  - Adds output dropped_cnt [15:0]: increments per dropped pixel, saturates at 16'hFFFF, and is cleared by reset.
- Undefined: every accepted pixel is written using the raw address; out-of-range coordinates land in off-screen SRAM. No dropped_cnt port exists.

Decomposition:
- Package display_pkg holds:
  - H_ACTIVE=640 and V_ACTIVE=480.
  - Pixel struct {x, y, r, g, b}.
  - FSM state enum.
  - pack_rgb565() and pixel_addr() functions.
- Sub-module pixel_fifo: synchronous FIFO with parameterized width and depth, full/empty flags, and same-cycle push/pop.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles → wr_ready=0, busy=0, SRAM pins Z; after release, wr_ready=1.
- Single write: push x=5, y=3, r=6'h3F, g=0, b=6'h21 → during STROBE, SRAM_ADDR=20'h00C05, DQ=16'hF810, WE_N=0 only on enable cycles; then IDLE, busy=0.
- Enable held low: push 4 pixels → no SRAM activity and pins Z; busy=1. When enable resumes toggling, 4 STROBE slots occur in push order.
- Full FIFO: push 16 pixels with enable=0 → wr_ready=0 after the 16th. A 17th wr_valid is held off; once enable toggles, after the first pop the 17th is accepted, in order.
- Reset mid-STROBE: assert rst_n=0 → pins Z on the next cycle; FIFO empty; no further writes after release.
- Clip (macro defined): push x=640, y=0, then x=639, y=479 → one write only, at 20'h77E7F; dropped_cnt=1.
